// File: rtl/password_verifier.sv
// ---------------------------------------------------------------------------
// password_verifier
//
// Keypad door controller for ten users. A user enters four BCD digits.
// Pressing enter compares them with that user's stored 16-bit password. A
// match opens the door for UNLOCK_CYCLES cycles. MAX_FAIL consecutive
// failures raise the alarm for LOCKOUT_CYCLES cycles.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   stored_pw    in   [159:0] ten passwords, user k at [16k-1:16k-16],
//                     digit4 in the top nibble, digit1 in the bottom nibble
//   user_sel     in   [3:0] user ID, valid range 1..10
//   digit_in     in   [3:0] BCD key value, valid range 0..9
//   digit_valid  in   one-cycle strobe: digit_in is presented
//   enter        in   one-cycle strobe: submit the entry
//   cancel       in   one-cycle strobe: abandon the entry
//   door_open    out  high for UNLOCK_CYCLES cycles after a match
//   alarm        out  high for LOCKOUT_CYCLES cycles after lockout
//   fail_count   out  [2:0] consecutive failed attempts
//   digit_count  out  [2:0] digits captured in the current entry (0..4)
//   state        out  [2:0] FSM state: IDLE=0 ENTRY=1 CHECK=2 UNLOCK=3
//                     LOCKOUT=4
//
// Handshake: digit_valid, enter and cancel are single-cycle strobes with no
// back-pressure. A strobe is consumed in the cycle it is high when the current
// state accepts it. Otherwise it is dropped with no side effect. The block
// never stalls the keypad and never asks for a strobe to be repeated.
// ---------------------------------------------------------------------------
module password_verifier #(
  parameter int UNLOCK_CYCLES  = 100,
  parameter int LOCKOUT_CYCLES = 200,
  parameter int MAX_FAIL       = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [159:0] stored_pw,
  input  logic [3:0]   user_sel,
  input  logic [3:0]   digit_in,
  input  logic         digit_valid,
  input  logic         enter,
  input  logic         cancel,
  output logic         door_open,
  output logic         alarm,
  output logic [2:0]   fail_count,
  output logic [2:0]   digit_count,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_UNLOCK  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  // The timer only needs to hold CYCLES-1. It is sized for the larger of the
  // two periods, so neither load value can wrap.
  localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                              UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [2:0]    MAX_FAIL_V   = 3'(MAX_FAIL);

  // Registered state
  state_t        state_q;
  logic [15:0]   buf_q;      // {digit4, digit3, digit2, digit1}
  logic [3:0]    user_q;     // user latched on the first digit
  logic [2:0]    dcnt_q;
  logic [2:0]    fail_q;
  logic [TW-1:0] timer_q;

  // Next-state values
  state_t        state_d;
  logic [15:0]   buf_d;
  logic [3:0]    user_d;
  logic [2:0]    dcnt_d;
  logic [2:0]    fail_d;
  logic [TW-1:0] timer_d;

  // Decoded inputs and the compare path
  logic        user_ok;
  logic        digit_ok;
  logic [15:0] sel_pw;
  logic        match;
  logic [2:0]  fail_inc;

  assign user_ok  = (user_sel >= 4'd1) && (user_sel <= 4'd10);
  assign digit_ok = (digit_in <= 4'd9);
  assign fail_inc = fail_q + 3'd1;

  // stored_pw is read live, so an update made during ENTRY is seen in CHECK.
  always_comb begin
    sel_pw = '0;
    for (int k = 1; k <= 10; k++) begin
      if (user_q == 4'(k)) begin
        sel_pw = stored_pw[(k-1)*16 +: 16];
      end
    end
  end

  // A short entry never matches, whatever the buffer holds.
  assign match = (dcnt_q == 3'd4) && (buf_q == sel_pw);

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    user_d  = user_q;
    dcnt_d  = dcnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        if (digit_valid && user_ok && digit_ok) begin
          user_d  = user_sel;
          buf_d   = {digit_in, 12'h000};
          dcnt_d  = 3'd1;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        // Priority is cancel, then enter, then digit_valid.
        if (cancel) begin
          dcnt_d  = 3'd0;
          buf_d   = '0;
          state_d = S_IDLE;
        end else if (enter) begin
          state_d = S_CHECK;
        end else if (digit_valid && digit_ok) begin
          // Digits fill from digit4 down to digit1. A fifth digit is dropped.
          case (dcnt_q)
            3'd1: begin
              buf_d[11:8] = digit_in;
              dcnt_d      = 3'd2;
            end
            3'd2: begin
              buf_d[7:4] = digit_in;
              dcnt_d     = 3'd3;
            end
            3'd3: begin
              buf_d[3:0] = digit_in;
              dcnt_d     = 3'd4;
            end
            default: ;
          endcase
        end
      end

      S_CHECK: begin
        dcnt_d = 3'd0;
        buf_d  = '0;
        if (match) begin
          fail_d  = 3'd0;
          timer_d = UNLOCK_LOAD;
          state_d = S_UNLOCK;
        end else if (fail_inc >= MAX_FAIL_V) begin
          // Saturate at MAX_FAIL. The count clears when LOCKOUT ends.
          fail_d  = MAX_FAIL_V;
          timer_d = LOCKOUT_LOAD;
          state_d = S_LOCKOUT;
        end else begin
          fail_d  = fail_inc;
          state_d = S_IDLE;
        end
      end

      S_UNLOCK: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d  = 3'd0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      user_q  <= '0;
      dcnt_q  <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      user_q  <= user_d;
      dcnt_q  <= dcnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  // Both indicators come straight from the state register. They are therefore
  // glitch-free and can never be high together.
  assign door_open   = (state_q == S_UNLOCK);
  assign alarm       = (state_q == S_LOCKOUT);
  assign fail_count  = fail_q;
  assign digit_count = dcnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_password_verifier.sv
// ---------------------------------------------------------------------------
// tb_password_verifier
//
// Bench for password_verifier. The observed status is the tuple
// {state, fail_count, digit_count, door_open, alarm}. Each time this tuple
// changes, the monitor forms a record and compares it with the next expected
// record. Each record also carries the number of cycles the previous tuple was
// held. An expected dwell of 0 means the dwell is not checked.
// ---------------------------------------------------------------------------
module tb_password_verifier;

  localparam int W = 27;  // {dwell[15:0], state[2:0], fail[2:0], dcnt[2:0], door, alarm}

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [159:0] stored_pw;
  logic [3:0]   user_sel;
  logic [3:0]   digit_in;
  logic         digit_valid;
  logic         enter;
  logic         cancel;
  logic         door_open;
  logic         alarm;
  logic [2:0]   fail_count;
  logic [2:0]   digit_count;
  logic [2:0]   state;

  password_verifier #(
    .UNLOCK_CYCLES (100),
    .LOCKOUT_CYCLES(200),
    .MAX_FAIL      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stored_pw  (stored_pw),
    .user_sel   (user_sel),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .enter      (enter),
    .cancel     (cancel),
    .door_open  (door_open),
    .alarm      (alarm),
    .fail_count (fail_count),
    .digit_count(digit_count),
    .state      (state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  task automatic e(input int dw, input logic [2:0] st, input logic [2:0] fc,
                   input logic [2:0] dc, input logic dr, input logic al);
    exp_q.push_back({16'(dw), st, fc, dc, dr, al});
  endtask

  // Monitor
  logic [10:0]  prev_stat;
  logic         first = 1'b1;
  int           dwell = 0;
  logic [10:0]  cur_stat;
  logic [W-1:0] act_rec;
  logic [W-1:0] exp_rec;

  always @(negedge clk) begin
    if (mon_en) begin
      cur_stat = {state, fail_count, digit_count, door_open, alarm};
      if (first || (cur_stat != prev_stat)) begin
        act_rec = {16'(dwell), cur_stat};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got st=%0d fc=%0d dc=%0d door=%0b alarm=%0b dwell=%0d, required no change",
                   state, fail_count, digit_count, door_open, alarm, dwell);
        end else begin
          exp_rec = exp_q.pop_front();
          if ((exp_rec[10:0] != act_rec[10:0]) ||
              ((exp_rec[26:11] != 16'd0) && (exp_rec[26:11] != act_rec[26:11]))) begin
            n_bad++;
            $display("FAIL status_event #%0d: got st=%0d fc=%0d dc=%0d door=%0b alarm=%0b dwell=%0d, required st=%0d fc=%0d dc=%0d door=%0b alarm=%0b dwell=%0d",
                     n_cmp, act_rec[10:8], act_rec[7:5], act_rec[4:2], act_rec[1], act_rec[0],
                     act_rec[26:11], exp_rec[10:8], exp_rec[7:5], exp_rec[4:2], exp_rec[1],
                     exp_rec[0], exp_rec[26:11]);
          end
        end
        dwell = 1;
        first = 1'b0;
      end else begin
        dwell++;
      end
      prev_stat = cur_stat;
    end
  end

  // Driver tasks. Each task starts and returns 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
  endtask

  task automatic enter_key();
    enter = 1'b1;
    @(posedge clk);
    #1;
    enter = 1'b0;
  endtask

  task automatic cancel_key();
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_pw(input int k, input logic [15:0] v);
    stored_pw[(k-1)*16 +: 16] = v;
  endtask

  // Stimulus
  initial begin
    reset       = 1'b1;
    user_sel    = 4'd0;
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    enter       = 1'b0;
    cancel      = 1'b0;
    stored_pw   = {10{16'h9999}};
    set_pw(1,  16'h0001);
    set_pw(2,  16'h4321);
    set_pw(3,  16'h0003);
    set_pw(10, 16'h0010);
    idle(3);
    reset = 1'b0;
    e(0, 0, 0, 0, 0, 0);          // reset state
    mon_en = 1'b1;
    idle(2);

    // User 3 enters the correct code 0,0,0,3. The door opens for 100 cycles
    // and inputs during UNLOCK are ignored.
    user_sel = 4'd3;
    e(0, 1, 0, 1, 0, 0); press(4'd0);
    e(0, 1, 0, 2, 0, 0); press(4'd0);
    e(0, 1, 0, 3, 0, 0); press(4'd0);
    e(0, 1, 0, 4, 0, 0); press(4'd3);
    e(0, 2, 0, 4, 0, 0);
    e(0, 3, 0, 0, 1, 0);
    e(100, 0, 0, 0, 0, 0);
    enter_key();
    idle(5);
    press(4'd5);
    cancel_key();
    idle(100);

    // User 1 fails three times. The third failure locks out for 200 cycles,
    // and inputs during LOCKOUT (cancel included) are ignored.
    user_sel = 4'd1;
    for (int a = 0; a < 3; a++) begin
      e(0, 1, 3'(a), 1, 0, 0); press(4'd1);
      e(0, 1, 3'(a), 2, 0, 0); press(4'd2);
      e(0, 1, 3'(a), 3, 0, 0); press(4'd3);
      e(0, 1, 3'(a), 4, 0, 0); press(4'd4);
      e(0, 2, 3'(a), 4, 0, 0);
      if (a < 2) e(0, 0, 3'(a + 1), 0, 0, 0);
      else       e(0, 4, 3, 0, 0, 1);
      enter_key();
      idle(2);
    end
    e(200, 0, 0, 0, 0, 0);
    idle(3);
    cancel_key();
    press(4'd1);
    enter_key();
    idle(200);

    // User 10 with a short entry is a mismatch. A five-digit entry drops the
    // fifth digit and matches, which also clears fail_count.
    user_sel = 4'd10;
    e(0, 1, 0, 1, 0, 0); press(4'd0);
    e(0, 1, 0, 2, 0, 0); press(4'd0);
    e(0, 2, 0, 2, 0, 0);
    e(0, 0, 1, 0, 0, 0);
    enter_key();
    idle(2);
    e(0, 1, 1, 1, 0, 0); press(4'd0);
    e(0, 1, 1, 2, 0, 0); press(4'd0);
    e(0, 1, 1, 3, 0, 0); press(4'd1);
    e(0, 1, 1, 4, 0, 0); press(4'd0);
    press(4'd7);
    e(0, 2, 1, 4, 0, 0);
    e(0, 3, 0, 0, 1, 0);
    e(100, 0, 0, 0, 0, 0);
    enter_key();
    idle(106);

    // Invalid users and invalid digits are ignored. A user_sel change after
    // the first digit does not affect which user is checked.
    user_sel = 4'd0;  press(4'd5);
    user_sel = 4'd11; press(4'd5);
    user_sel = 4'd2;
    e(0, 1, 0, 1, 0, 0); press(4'd4);
    press(4'd12);
    press(4'd15);
    user_sel = 4'd3;
    e(0, 1, 0, 2, 0, 0); press(4'd3);
    e(0, 1, 0, 3, 0, 0); press(4'd2);
    e(0, 1, 0, 4, 0, 0); press(4'd1);
    e(0, 2, 0, 4, 0, 0);
    e(0, 3, 0, 0, 1, 0);
    e(100, 0, 0, 0, 0, 0);
    enter_key();
    idle(106);

    // Cancel together with enter and a digit at digit_count=3 returns to IDLE
    // and keeps fail_count. An enter strobe in IDLE is ignored.
    user_sel = 4'd1;
    e(0, 1, 0, 1, 0, 0); press(4'd9);
    e(0, 2, 0, 1, 0, 0);
    e(0, 0, 1, 0, 0, 0);
    enter_key();
    idle(2);
    e(0, 1, 1, 1, 0, 0); press(4'd1);
    e(0, 1, 1, 2, 0, 0); press(4'd2);
    e(0, 1, 1, 3, 0, 0); press(4'd3);
    e(0, 0, 1, 0, 0, 0);
    cancel = 1'b1; enter = 1'b1; digit_valid = 1'b1; digit_in = 4'd4;
    @(posedge clk);
    #1;
    cancel = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    idle(2);
    enter_key();
    idle(2);

    // A password update made during ENTRY applies to the compare. A reset in
    // the middle of UNLOCK returns the block to IDLE.
    e(0, 1, 1, 1, 0, 0); press(4'd5);
    e(0, 1, 1, 2, 0, 0); press(4'd6);
    set_pw(1, 16'h5678);
    e(0, 1, 1, 3, 0, 0); press(4'd7);
    e(0, 1, 1, 4, 0, 0); press(4'd8);
    e(0, 2, 1, 4, 0, 0);
    e(0, 3, 0, 0, 1, 0);
    enter_key();
    idle(10);
    e(0, 0, 0, 0, 0, 0);
    do_reset();
    idle(2);

    // Force a lockout, then reset in the middle of LOCKOUT.
    set_pw(1, 16'h0001);
    for (int a = 0; a < 3; a++) begin
      e(0, 1, 3'(a), 1, 0, 0); press(4'd2);
      e(0, 2, 3'(a), 1, 0, 0);
      if (a < 2) e(0, 0, 3'(a + 1), 0, 0, 0);
      else       e(0, 4, 3, 0, 0, 1);
      enter_key();
      idle(2);
    end
    idle(3);
    cancel_key();
    press(4'd2);
    idle(15);
    e(0, 0, 0, 0, 0, 0);
    do_reset();
    idle(5);

    // Final report
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d unobserved expected events, required 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
